// File: rtl/ni_flit_engine.sv
// Network interface: packetises processor words into router flit streams
// and reassembles incoming flit streams into processor words.
module ni_flit_engine #(
    parameter int FLIT_W = 8,
    parameter int NFLITS = 4,
    parameter int ADDR_W = 2,
    parameter logic [FLIT_W-ADDR_W-1:0] HDR_TAG = 'b101111,
    parameter bit TRIM = 1'b1,
    parameter int LEN_W = $clog2(NFLITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W*NFLITS-1:0] tx_data,
    input  logic [ADDR_W-1:0]        tx_dest,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [FLIT_W-1:0]        flit_out,
    output logic                     flit_out_valid,
    input  logic                     flit_out_ready,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic                     flit_in_valid,
    output logic                     flit_in_ready,
    output logic [FLIT_W*NFLITS-1:0] rx_data,
    output logic [ADDR_W-1:0]        rx_dest,
    output logic [LEN_W-1:0]         rx_len,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_err
);

    localparam int PAY_W = FLIT_W * NFLITS;
    localparam logic [FLIT_W-1:0] TAIL = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NFLITS);

    typedef enum logic [1:0] {T_IDLE, T_HEAD, T_DATA, T_TAIL} tx_state_t;
    typedef enum logic [1:0] {R_HEAD, R_DATA, R_TAIL, R_HOLD} rx_state_t;

    // Number of payload flits to send for a given word.
    function automatic logic [LEN_W-1:0] calc_len(input logic [PAY_W-1:0] d);
        logic [LEN_W-1:0] l;
        l = TRIM ? '0 : LEN_MAX;
        if (TRIM) begin
            for (int i = 0; i < NFLITS; i++) begin
                if (d[i*FLIT_W +: FLIT_W] != '0) l = LEN_W'(i + 1);
            end
        end
        return l;
    endfunction

    // ---------------- TX ----------------
    tx_state_t          tx_state, tx_state_n;
    logic [PAY_W-1:0]   tx_buf, tx_buf_n;
    logic [LEN_W-1:0]   tx_rem, tx_rem_n;
    logic [FLIT_W-1:0]  flit_out_n;
    logic               flit_out_valid_n;
    logic               tx_fire;

    assign tx_fire  = flit_out_valid && flit_out_ready;
    assign tx_ready = (tx_state == T_IDLE);

    always_comb begin
        tx_state_n       = tx_state;
        tx_buf_n         = tx_buf;
        tx_rem_n         = tx_rem;
        flit_out_n       = flit_out;
        flit_out_valid_n = flit_out_valid;
        unique case (tx_state)
            T_IDLE: begin
                if (tx_valid) begin
                    tx_buf_n         = tx_data;
                    tx_rem_n         = calc_len(tx_data);
                    flit_out_n       = {HDR_TAG, tx_dest};
                    flit_out_valid_n = 1'b1;
                    tx_state_n       = T_HEAD;
                end
            end
            // tx_rem counts payload flits not yet presented; buffer shifts down.
            T_HEAD, T_DATA: begin
                if (tx_fire) begin
                    if (tx_rem != '0) begin
                        flit_out_n = tx_buf[FLIT_W-1:0];
                        tx_buf_n   = tx_buf >> FLIT_W;
                        tx_rem_n   = tx_rem - LEN_W'(1);
                        tx_state_n = T_DATA;
                    end else begin
                        flit_out_n = TAIL;
                        tx_state_n = T_TAIL;
                    end
                end
            end
            T_TAIL: begin
                if (tx_fire) begin
                    flit_out_valid_n = 1'b0;
                    tx_state_n       = T_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state       <= T_IDLE;
            tx_buf         <= '0;
            tx_rem         <= '0;
            flit_out       <= '0;
            flit_out_valid <= 1'b0;
        end else begin
            tx_state       <= tx_state_n;
            tx_buf         <= tx_buf_n;
            tx_rem         <= tx_rem_n;
            flit_out       <= flit_out_n;
            flit_out_valid <= flit_out_valid_n;
        end
    end

    // ---------------- RX ----------------
    rx_state_t          rx_state, rx_state_n;
    logic [LEN_W-1:0]   rx_cnt, rx_cnt_n;
    logic [PAY_W-1:0]   rx_data_n;
    logic [ADDR_W-1:0]  rx_dest_n;
    logic [LEN_W-1:0]   rx_len_n;
    logic               rx_err_n;
    logic               rx_acc;
    logic               tag_ok;
    logic               is_tail;

    assign flit_in_ready = (rx_state != R_HOLD);
    assign rx_valid      = (rx_state == R_HOLD);
    assign rx_acc        = flit_in_valid && flit_in_ready;
    assign tag_ok        = (flit_in[FLIT_W-1:ADDR_W] == HDR_TAG);
    assign is_tail       = (flit_in == TAIL);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_data_n  = rx_data;
        rx_dest_n  = rx_dest;
        rx_len_n   = rx_len;
        rx_err_n   = 1'b0;
        unique case (rx_state)
            R_HEAD: begin
                if (rx_acc) begin
                    if (tag_ok) begin
                        rx_dest_n  = flit_in[ADDR_W-1:0];
                        rx_data_n  = '0;
                        rx_cnt_n   = '0;
                        rx_state_n = R_DATA;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (rx_acc) begin
                    if (TRIM && is_tail) begin
                        rx_len_n   = rx_cnt;
                        rx_state_n = R_HOLD;
                    end else begin
                        for (int i = 0; i < NFLITS; i++) begin
                            if (rx_cnt == LEN_W'(i))
                                rx_data_n[i*FLIT_W +: FLIT_W] = flit_in;
                        end
                        rx_cnt_n = rx_cnt + LEN_W'(1);
                        if (rx_cnt + LEN_W'(1) == LEN_MAX) rx_state_n = R_TAIL;
                    end
                end
            end
            R_TAIL: begin
                if (rx_acc) begin
                    if (is_tail) begin
                        rx_len_n   = LEN_MAX;
                        rx_state_n = R_HOLD;
                    end else begin
                        rx_err_n   = 1'b1;
                        rx_state_n = R_HEAD;
                    end
                end
            end
            R_HOLD: begin
                if (rx_ready) rx_state_n = R_HEAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_HEAD;
            rx_cnt   <= '0;
            rx_data  <= '0;
            rx_dest  <= '0;
            rx_len   <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_data  <= rx_data_n;
            rx_dest  <= rx_dest_n;
            rx_len   <= rx_len_n;
            rx_err   <= rx_err_n;
        end
    end

endmodule

// File: tb/tb_ni_flit_engine.sv
// Bench for ni_flit_engine: directed TX/RX packets checked against a
// packet-level model of the flit protocol.
module tb_ni_flit_engine;

    localparam int FW = 8;
    localparam int NF = 4;
    localparam int AW = 2;
    localparam int PW = FW * NF;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [PW-1:0] tx_data = '0;
    logic [AW-1:0] tx_dest = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [FW-1:0] flit_out;
    logic          flit_out_valid;
    logic          flit_out_ready = 1'b1;
    logic [FW-1:0] flit_in = '0;
    logic          flit_in_valid = 1'b0;
    logic          flit_in_ready;
    logic [PW-1:0] rx_data;
    logic [AW-1:0] rx_dest;
    logic [LW-1:0] rx_len;
    logic          rx_valid;
    logic          rx_ready = 1'b1;
    logic          rx_err;

    logic          tx_valid0 = 1'b0;
    logic          tx_ready0;
    logic [FW-1:0] flit_out0;
    logic          flit_out_valid0;
    logic          flit_out_ready0 = 1'b1;
    logic          flit_in_valid0 = 1'b0;
    logic          flit_in_ready0;
    logic [PW-1:0] rx_data0;
    logic [AW-1:0] rx_dest0;
    logic [LW-1:0] rx_len0;
    logic          rx_valid0;
    logic          rx_ready0 = 1'b1;
    logic          rx_err0;

    ni_flit_engine dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_dest(tx_dest),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid),
        .flit_out_ready(flit_out_ready),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .rx_data(rx_data), .rx_dest(rx_dest), .rx_len(rx_len),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_err(rx_err)
    );

    ni_flit_engine #(.TRIM(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_dest(tx_dest),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .flit_out(flit_out0), .flit_out_valid(flit_out_valid0),
        .flit_out_ready(flit_out_ready0),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid0),
        .flit_in_ready(flit_in_ready0),
        .rx_data(rx_data0), .rx_dest(rx_dest0), .rx_len(rx_len0),
        .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_err(rx_err0)
    );

    typedef struct {
        logic [PW-1:0] d;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } rx_t;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    bit tog = 1'b0;
    logic [FW-1:0] exp_tx[$];
    logic [FW-1:0] exp_tx0[$];
    logic [FW-1:0] log_tx[$];
    logic [FW-1:0] log_tx0[$];
    logic [FW-1:0] rx_pkt[$];
    rx_t exp_rx[$];
    rx_t last_rx;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Packet model: header, payload up to the last nonzero flit, tail.
    function automatic void model_tx(input logic [PW-1:0] d,
                                     input logic [AW-1:0] a, input bit trim);
        int l;
        logic [FW-1:0] f[$];
        l = trim ? 0 : NF;
        if (trim)
            for (int i = 0; i < NF; i++)
                if (d[FW*i +: FW] != 0) l = i + 1;
        f.push_back({6'b101111, a});
        for (int i = 0; i < l; i++) f.push_back(d[FW*i +: FW]);
        f.push_back(8'hFF);
        foreach (f[i]) begin
            if (trim) exp_tx.push_back(f[i]);
            else exp_tx0.push_back(f[i]);
        end
    endfunction

    // Well-formed packet in rx_pkt -> expected word.
    function automatic void model_rx();
        rx_t r;
        int i;
        r.a = rx_pkt[0][AW-1:0];
        r.d = '0;
        r.l = '0;
        i = 1;
        while (i < rx_pkt.size() && rx_pkt[i] != 8'hFF) begin
            r.d[FW*(i-1) +: FW] = rx_pkt[i];
            r.l = r.l + 1'b1;
            i++;
        end
        exp_rx.push_back(r);
    endfunction

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [FW-1:0] pf = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("tx_hold_flit", flit_out, pf);
                check("tx_hold_valid", flit_out_valid, 1);
            end
            if (flit_out_valid) begin
                if (exp_tx.size() == 0) check("tx_extra", flit_out, 32'hFFFF);
                else begin
                    check("tx_flit", flit_out, exp_tx[0]);
                    if (flit_out_ready) begin
                        log_tx.push_back(flit_out);
                        void'(exp_tx.pop_front());
                    end
                end
            end
            pv = flit_out_valid;
            pr = flit_out_ready;
            pf = flit_out;
            if (flit_out_valid0) begin
                if (exp_tx0.size() == 0) check("tx0_extra", flit_out0, 32'hFFFF);
                else begin
                    check("tx0_flit", flit_out0, exp_tx0[0]);
                    log_tx0.push_back(flit_out0);
                    void'(exp_tx0.pop_front());
                end
            end
            if (rx_valid) begin
                check("rx_in_ready_low", flit_in_ready, 0);
                if (exp_rx.size() == 0) check("rx_extra", 1, 0);
                else begin
                    check("rx_data", rx_data, exp_rx[0].d);
                    check("rx_dest", rx_dest, exp_rx[0].a);
                    check("rx_len", rx_len, exp_rx[0].l);
                    if (rx_ready) begin
                        last_rx.d = rx_data;
                        last_rx.a = rx_dest;
                        last_rx.l = rx_len;
                        void'(exp_rx.pop_front());
                    end
                end
            end
            if (rx_err) err_seen++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        flit_out_ready = tog ? ~flit_out_ready : 1'b1;
    end

    task automatic tx_send(input logic [PW-1:0] d, input logic [AW-1:0] a,
                           input bit use0);
        int t;
        model_tx(d, a, !use0);
        tx_data = d;
        tx_dest = a;
        if (use0) tx_valid0 = 1'b1;
        else tx_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(use0 ? tx_ready0 : tx_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("tx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
        tx_valid0 = 1'b0;
    endtask

    task automatic wait_tx_done();
        int t;
        t = 0;
        while (t < 200 && (exp_tx.size() != 0 || exp_tx0.size() != 0 ||
                           flit_out_valid || flit_out_valid0)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("tx_done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send();
        int t;
        foreach (rx_pkt[k]) begin
            flit_in = rx_pkt[k];
            flit_in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!flit_in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check("rx_in_timeout", 0, 1);
                flit_in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        flit_in_valid = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_flit_out", flit_out, 0);
        check("rst_flit_out_valid", flit_out_valid, 0);
        check("rst_flit_in_ready", flit_in_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_dest", rx_dest, 0);
        check("rst_rx_len", rx_len, 0);
        check("rst_rx_err", rx_err, 0);
    endtask

    task automatic check_log(input string nm, input logic [63:0] lit,
                             input int n);
        logic [63:0] v;
        v = lit;
        check({nm, "_count"}, log_tx.size(), n);
        for (int i = 0; i < n && i < log_tx.size(); i++)
            check(nm, log_tx[i], v[FW*(n-1-i) +: FW]);
    endtask

    initial begin
        int n;
        int e0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int e0;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: trimmed packet and word-to-word period
        log_tx.delete();
        tx_send(32'h000012A5, 2'd1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 20);
        check("tx_period", n, 5);
        @(posedge clk);
        #1;
        wait_tx_done();
        check_log("t1_seq", 64'hBDA512FF, 4);

        // 2: all-zero payload, trimmed and untrimmed
        log_tx.delete();
        tx_send(32'h0, 2'd2, 1'b0);
        wait_tx_done();
        check_log("t2_seq", 64'hBEFF, 2);
        log_tx0.delete();
        tx_send(32'h0, 2'd2, 1'b1);
        wait_tx_done();
        check("t2_trim0_count", log_tx0.size(), 6);
        if (log_tx0.size() == 6) begin
            check("t2_trim0_head", log_tx0[0], 8'hBE);
            check("t2_trim0_d3", log_tx0[4], 8'h00);
            check("t2_trim0_tail", log_tx0[5], 8'hFF);
        end

        // 3 with 4 in parallel: stalled TX, held RX
        log_tx.delete();
        tog = 1'b1;
        fork
            begin
                tx_send(32'h44332211, 2'd0, 1'b0);
                wait_tx_done();
            end
            begin
                rx_ready = 1'b0;
                rx_pkt = '{8'hBD, 8'hA5, 8'h12, 8'hFF};
                model_rx();
                rx_send();
                repeat (5) begin
                    @(negedge clk);
                    check("t4_rx_valid_hold", rx_valid, 1);
                end
                @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                check("t4_rx_valid_drop", rx_valid, 0);
                check("t4_in_ready_back", flit_in_ready, 1);
                @(posedge clk);
                #1;
            end
        join
        tog = 1'b0;
        check_log("t3_seq", 64'hBC11223344FF, 6);
        check("t4_lit_data", last_rx.d, 32'h000012A5);
        check("t4_lit_dest", last_rx.a, 1);
        check("t4_lit_len", last_rx.l, 2);

        // 5: bad header, missing tail, then a short good packet
        e0 = err_seen;
        rx_pkt = '{8'h3D};
        rx_send();
        repeat (2) @(posedge clk);
        #1;
        check("t5_err_hdr", err_seen - e0, 1);
        rx_pkt = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        rx_send();
        repeat (2) @(posedge clk);
        #1;
        check("t5_err_tail", err_seen - e0, 2);
        rx_pkt = '{8'hBC, 8'h11, 8'hFF};
        model_rx();
        rx_send();
        repeat (3) @(posedge clk);
        #1;
        check("t5_rx_consumed", exp_rx.size(), 0);
        check("t5_lit_data", last_rx.d, 32'h00000011);
        check("t5_lit_len", last_rx.l, 1);
        check("t5_lit_dest", last_rx.a, 0);
        check("t5_err_total", err_seen - e0, 2);

        // 6: reset after the second fired flit
        log_tx.delete();
        tx_send(32'h00778899, 2'd1, 1'b0);
        n = 0;
        while (log_tx.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_two_fires", log_tx.size(), 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        exp_tx.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        log_tx.delete();
        tx_send(32'h1, 2'd3, 1'b0);
        wait_tx_done();
        check_log("t6_seq", 64'hBF01FF, 3);
        check("end_rx_queue", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
